axi_traffic_gen: RTL and testbench

- Synthesisable AXI4 initiator that drives one master port of the 16-port mesh during throughput runs.
- Issues a programmable sequence of INCR write bursts and/or read bursts with a deterministic data pattern.
- Checks returned read data and IDs, and reports cycle and error counts so the bench measures per-master throughput.
- Sixteen instances sit in front of the mesh slave inputs, alongside the PMUs.

---
 rtl/axi_traffic_gen.sv | 273 +++++++++++++++++++++++++++
 tb/tb_axi_traffic_gen.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_traffic_gen.sv
// AXI4 traffic initiator: issues INCR write/read bursts with an XOR data
// pattern and checks read data and IDs, one burst outstanding at a time.
module axi_traffic_gen #(
  parameter logic [3:0] MASTER_ID    = 4'd0,
  parameter logic [7:0] PATTERN_SEED = 8'hA5,
  parameter int         CNT_W        = 32
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [15:0]      num_bursts,
  input  logic [15:0]      base_addr,
  input  logic [15:0]      stride,
  input  logic [7:0]       burst_len,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [31:0]      beat_cnt,
  output logic [15:0]      err_cnt,
  output logic             awvalid,
  output logic [3:0]       awid,
  output logic [15:0]      awaddr,
  output logic [7:0]       awlen,
  output logic [2:0]       awsize,
  output logic [1:0]       awburst,
  input  logic             awready,
  output logic             wvalid,
  output logic [7:0]       wdata,
  output logic             wstrb,
  output logic             wlast,
  input  logic             wready,
  input  logic             bvalid,
  input  logic [3:0]       bid,
  output logic             bready,
  output logic             arvalid,
  output logic [3:0]       arid,
  output logic [15:0]      araddr,
  output logic [7:0]       arlen,
  output logic [2:0]       arsize,
  output logic [1:0]       arburst,
  input  logic             arready,
  input  logic             rvalid,
  input  logic [3:0]       rid,
  input  logic [7:0]       rdata,
  input  logic             rlast,
  output logic             rready
);

  typedef enum logic [2:0] {
    S_IDLE, S_WA, S_WD, S_WB, S_RA, S_RD, S_DONE
  } state_t;

  state_t           r_state;
  logic             r_rd_after;
  logic [15:0]      r_num;
  logic [15:0]      r_base;
  logic [15:0]      r_stride;
  logic [15:0]      r_addr;
  logic [15:0]      r_i;
  logic [7:0]       r_len;
  logic [7:0]       r_j;
  logic             r_late;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_cyc;
  logic [31:0]      r_beat;
  logic [15:0]      r_err;
  logic             r_awvalid;
  logic             r_wvalid;
  logic [7:0]       r_wdata;
  logic             r_wlast;
  logic             r_bready;
  logic             r_arvalid;
  logic             r_rready;

  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_b_hs;
  logic        w_ar_hs;
  logic        w_r_hs;
  logic        w_last_burst;
  logic [15:0] w_next_addr;
  logic [7:0]  w_rexp;
  logic [7:0]  w_wnext;
  logic        w_rbeat_bad;
  logic        w_rlast_bad;
  logic        w_bid_bad;
  logic [1:0]  w_err_inc;
  logic [16:0] w_err_sum;
  logic [15:0] w_err_next;

  assign w_aw_hs      = r_awvalid & awready;
  assign w_w_hs       = r_wvalid & wready;
  assign w_b_hs       = r_bready & bvalid;
  assign w_ar_hs      = r_arvalid & arready;
  assign w_r_hs       = r_rready & rvalid;
  assign w_last_burst = (r_i == r_num - 16'd1);
  assign w_next_addr  = r_addr + r_stride;
  assign w_rexp       = (r_addr[7:0] + r_j) ^ PATTERN_SEED;
  assign w_wnext      = (r_addr[7:0] + r_j + 8'd1) ^ PATTERN_SEED;
  assign w_rbeat_bad  = (rdata != w_rexp) || (rid != MASTER_ID);
  assign w_bid_bad    = (bid != MASTER_ID);

  // rlast must coincide with beat burst_len; a late one is counted only once
  assign w_rlast_bad = !r_late && (rlast != (r_j == r_len));

  assign w_err_inc  = {1'b0, w_r_hs & w_rbeat_bad}
                    + {1'b0, w_r_hs & w_rlast_bad}
                    + {1'b0, w_b_hs & w_bid_bad};
  assign w_err_sum  = {1'b0, r_err} + {15'd0, w_err_inc};
  assign w_err_next = w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= S_IDLE;
      r_rd_after <= 1'b0;
      r_num      <= '0;
      r_base     <= '0;
      r_stride   <= '0;
      r_addr     <= '0;
      r_i        <= '0;
      r_len      <= '0;
      r_j        <= '0;
      r_late     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cyc      <= '0;
      r_beat     <= '0;
      r_err      <= '0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_wdata    <= '0;
      r_wlast    <= 1'b0;
      r_bready   <= 1'b0;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
    end else begin
      if (r_busy) r_cyc <= r_cyc + CNT_W'(1);
      r_beat <= r_beat + 32'(w_w_hs) + 32'(w_r_hs);
      r_err  <= w_err_next;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_rd_after <= mode[1];
            r_num      <= num_bursts;
            r_base     <= base_addr;
            r_stride   <= stride;
            r_len      <= burst_len;
            r_i        <= '0;
            r_addr     <= base_addr;
            r_cyc      <= '0;
            r_beat     <= '0;
            r_err      <= '0;
            if (num_bursts == 16'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_done <= 1'b0;
              r_busy <= 1'b1;
              if (mode == 2'd1) begin
                r_state   <= S_RA;
                r_arvalid <= 1'b1;
              end else begin
                r_state   <= S_WA;
                r_awvalid <= 1'b1;
              end
            end
          end
        end
        S_WA: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b1;
            r_j       <= '0;
            r_wdata   <= r_addr[7:0] ^ PATTERN_SEED;
            r_wlast   <= (r_len == 8'd0);
            r_state   <= S_WD;
          end
        end
        S_WD: begin
          if (w_w_hs) begin
            if (r_wlast) begin
              r_wvalid <= 1'b0;
              r_wlast  <= 1'b0;
              r_bready <= 1'b1;
              r_state  <= S_WB;
            end else begin
              r_j     <= r_j + 8'd1;
              r_wdata <= w_wnext;
              r_wlast <= (r_j + 8'd1 == r_len);
            end
          end
        end
        S_WB: begin
          if (w_b_hs) begin
            r_bready <= 1'b0;
            if (!w_last_burst) begin
              r_i       <= r_i + 16'd1;
              r_addr    <= w_next_addr;
              r_awvalid <= 1'b1;
              r_state   <= S_WA;
            end else if (r_rd_after) begin
              r_i       <= '0;
              r_addr    <= r_base;
              r_arvalid <= 1'b1;
              r_state   <= S_RA;
            end else begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_RA: begin
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_j       <= '0;
            r_late    <= 1'b0;
            r_state   <= S_RD;
          end
        end
        S_RD: begin
          if (w_r_hs) begin
            r_j <= r_j + 8'd1;
            if (!rlast && r_j == r_len) r_late <= 1'b1;
            if (rlast) begin
              r_rready <= 1'b0;
              if (!w_last_burst) begin
                r_i       <= r_i + 16'd1;
                r_addr    <= w_next_addr;
                r_arvalid <= 1'b1;
                r_state   <= S_RA;
              end else begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign cycle_cnt = r_cyc;
  assign beat_cnt  = r_beat;
  assign err_cnt   = r_err;
  assign awvalid   = r_awvalid;
  assign awid      = MASTER_ID;
  assign awaddr    = r_addr;
  assign awlen     = r_len;
  assign awsize    = 3'b000;
  assign awburst   = 2'b01;
  assign wvalid    = r_wvalid;
  assign wdata     = r_wdata;
  assign wstrb     = 1'b1;
  assign wlast     = r_wlast;
  assign bready    = r_bready;
  assign arvalid   = r_arvalid;
  assign arid      = MASTER_ID;
  assign araddr    = r_addr;
  assign arlen     = r_len;
  assign arsize    = 3'b000;
  assign arburst   = 2'b01;
  assign rready    = r_rready;

endmodule

// File: tb/tb_axi_traffic_gen.sv
// Bench for axi_traffic_gen: byte-memory slave with stall and fault knobs,
// queue scoreboard for AW/W/AR traffic and end-of-run counter checks.
module tb_axi_traffic_gen;

  localparam logic [3:0] MID   = 4'h3;
  localparam logic [7:0] SEED  = 8'hA5;
  localparam int         LIMIT = 5000;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = '0;
  logic [15:0] num_bursts = '0;
  logic [15:0] base_addr = '0;
  logic [15:0] stride = '0;
  logic [7:0]  burst_len = '0;
  logic        busy, done;
  logic [31:0] cycle_cnt, beat_cnt;
  logic [15:0] err_cnt;
  logic        awvalid;
  logic [3:0]  awid;
  logic [15:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awready = 1'b0;
  logic        wvalid;
  logic [7:0]  wdata;
  logic        wstrb, wlast;
  logic        wready = 1'b0;
  logic        bvalid = 1'b0;
  logic [3:0]  bid = '0;
  logic        bready;
  logic        arvalid;
  logic [3:0]  arid;
  logic [15:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arready = 1'b0;
  logic        rvalid = 1'b0;
  logic [3:0]  rid = '0;
  logic [7:0]  rdata = '0;
  logic        rlast = 1'b0;
  logic        rready;

  int tests = 0;
  int fails = 0;

  logic [15:0] exp_aw[$];
  logic [15:0] exp_ar[$];
  logic [8:0]  exp_w[$];
  logic [7:0]  cur_len = '0;

  bit bp = 0, k_bad_bid = 0, k_zero = 0, k_bad_rid = 0, k_early = 0;

  logic [7:0]  mem [0:65535];
  logic [15:0] s_waddr = '0, s_wk = '0, s_raddr = '0, s_rk = '0;
  logic [7:0]  s_rlen = '0;
  bit          s_bpend = 0, s_ract = 0;

  always #5 aclk = ~aclk;

  axi_traffic_gen #(
    .MASTER_ID(MID), .PATTERN_SEED(SEED), .CNT_W(32)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .mode(mode),
    .num_bursts(num_bursts), .base_addr(base_addr), .stride(stride),
    .burst_len(burst_len), .busy(busy), .done(done),
    .cycle_cnt(cycle_cnt), .beat_cnt(beat_cnt), .err_cnt(err_cnt),
    .awvalid(awvalid), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wready(wready), .bvalid(bvalid), .bid(bid), .bready(bready),
    .arvalid(arvalid), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arready(arready),
    .rvalid(rvalid), .rid(rid), .rdata(rdata), .rlast(rlast),
    .rready(rready)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Expected pattern depends only on the byte address, so a good memory
  // image holds addr^SEED everywhere and a bad one holds its complement.
  task automatic fill_mem(input bit good);
    for (int a = 0; a < 65536; a++)
      mem[a] = good ? (8'(a) ^ SEED) : ~(8'(a) ^ SEED);
  endtask

  task automatic model(input logic [1:0] m, input logic [15:0] n, b, s,
                       input logic [7:0] l, output int beats, output int errs);
    logic [15:0] a;
    logic [7:0]  d;
    int          nb;
    bit          early;
    beats = 0;
    errs  = 0;
    early = k_early && (l != 8'd0);
    if (m != 2'd1) begin
      for (int i = 0; i < int'(n); i++) begin
        a = b + 16'(i) * s;
        exp_aw.push_back(a);
        for (int j = 0; j <= int'(l); j++) begin
          d = 8'(a + 16'(j)) ^ SEED;
          exp_w.push_back({j == int'(l), d});
          beats++;
        end
        if (k_bad_bid) errs++;
      end
    end
    if (m != 2'd0) begin
      for (int i = 0; i < int'(n); i++) begin
        a = b + 16'(i) * s;
        exp_ar.push_back(a);
        nb = early ? 1 : int'(l) + 1;
        for (int j = 0; j < nb; j++) begin
          d = 8'(a + 16'(j)) ^ SEED;
          beats++;
          if ((k_zero && d != 8'h00) || k_bad_rid) errs++;
        end
        if (early) errs++;
      end
    end
    if (errs > 65535) errs = 65535;
  endtask

  task automatic flush();
    exp_aw.delete();
    exp_w.delete();
    exp_ar.delete();
  endtask

  task automatic run(input logic [1:0] m, input logic [15:0] n, b, s,
                     input logic [7:0] l, input bit stall, input bit poke);
    int eb, ee, cyc;
    fill_mem(m == 2'd1);
    model(m, n, b, s, l, eb, ee);
    bp = stall;
    cur_len = l;
    @(posedge aclk); #1;
    mode = m; num_bursts = n; base_addr = b;
    stride = s; burst_len = l; start = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
    @(negedge aclk);
    chk("busy_run", busy, n != 16'd0);
    if (poke) begin
      @(posedge aclk); #1;
      mode = ~m; num_bursts = n + 16'd5; base_addr = ~b;
      burst_len = l + 8'd1; start = 1'b1;
      @(posedge aclk); #1;
      start = 1'b0;
    end
    cyc = 0;
    while (!done && cyc < LIMIT) begin
      @(negedge aclk);
      cyc++;
    end
    chk("run_done", done, 1);
    chk("run_busy_low", busy, 0);
    chk("run_beats", beat_cnt, eb);
    chk("run_errs", err_cnt, ee);
    chk("run_aw_left", exp_aw.size(), 0);
    chk("run_w_left", exp_w.size(), 0);
    chk("run_ar_left", exp_ar.size(), 0);
    flush();
  endtask

  // Slave: reacts at posedge+1 to handshakes sampled at the preceding negedge.
  always begin : slave
    bit          haw, hw, hb, har, hr, w_l;
    logic [15:0] aw_a, ar_a;
    logic [7:0]  w_d, ar_l;
    @(negedge aclk);
    haw  = aresetn && awvalid && awready;
    hw   = aresetn && wvalid && wready;
    hb   = aresetn && bvalid && bready;
    har  = aresetn && arvalid && arready;
    hr   = aresetn && rvalid && rready;
    aw_a = awaddr;
    w_d  = wdata;
    w_l  = wlast;
    ar_a = araddr;
    ar_l = arlen;
    @(posedge aclk);
    #1;
    if (!aresetn) begin
      awready = 1'b0; wready = 1'b0; arready = 1'b0;
      bvalid = 1'b0; rvalid = 1'b0; rlast = 1'b0;
      s_bpend = 0; s_ract = 0;
    end else begin
      if (hb) begin bvalid = 1'b0; s_bpend = 0; end
      if (haw) begin s_waddr = aw_a; s_wk = '0; end
      if (hw) begin
        mem[s_waddr + s_wk] = w_d;
        s_wk = s_wk + 16'd1;
        if (w_l) s_bpend = 1;
      end
      if (s_bpend && !bvalid) begin
        bvalid = 1'b1;
        bid = MID ^ {3'b000, k_bad_bid};
      end
      if (har) begin
        s_raddr = ar_a; s_rlen = ar_l; s_rk = '0; s_ract = 1;
      end
      if (hr) begin
        rvalid = 1'b0;
        if (rlast) s_ract = 0;
        else s_rk = s_rk + 16'd1;
      end
      if (s_ract && !rvalid && (!bp || $urandom_range(0, 1) == 1)) begin
        rvalid = 1'b1;
        rdata  = k_zero ? 8'h00 : mem[s_raddr + s_rk];
        rid    = MID ^ {3'b000, k_bad_rid};
        rlast  = k_early || (s_rk == 16'(s_rlen));
      end
      awready = !bp || ($urandom_range(0, 1) == 1);
      wready  = !bp || ($urandom_range(0, 1) == 1);
      arready = !bp || ($urandom_range(0, 1) == 1);
    end
  end

  logic        aw_stall = 1'b0, w_stall = 1'b0, ar_stall = 1'b0;
  logic [15:0] aw_p = '0, ar_p = '0;
  logic [8:0]  w_p = '0;

  always @(negedge aclk) begin : monitor
    if (!aresetn) begin
      aw_stall = 1'b0; w_stall = 1'b0; ar_stall = 1'b0;
    end else begin
      if (aw_stall) chk("aw_hold", {awvalid, awaddr}, {1'b1, aw_p});
      if (w_stall) chk("w_hold", {wvalid, wlast, wdata}, {1'b1, w_p});
      if (ar_stall) chk("ar_hold", {arvalid, araddr}, {1'b1, ar_p});
      if (awvalid && awready) begin
        if (exp_aw.size() == 0) begin
          tests++; fails++;
          $display("FAIL aw_extra: got addr %0h, required no burst", awaddr);
        end else
          chk("aw_req", {awid, awsize, awburst, awlen, awaddr},
              {MID, 3'b000, 2'b01, cur_len, exp_aw.pop_front()});
      end
      if (wvalid && wready) begin
        if (exp_w.size() == 0) begin
          tests++; fails++;
          $display("FAIL w_extra: got data %0h, required no beat", wdata);
        end else
          chk("w_beat", {wstrb, wlast, wdata}, {1'b1, exp_w.pop_front()});
      end
      if (arvalid && arready) begin
        if (exp_ar.size() == 0) begin
          tests++; fails++;
          $display("FAIL ar_extra: got addr %0h, required no burst", araddr);
        end else
          chk("ar_req", {arid, arsize, arburst, arlen, araddr},
              {MID, 3'b000, 2'b01, cur_len, exp_ar.pop_front()});
      end
      aw_stall = awvalid && !awready;
      aw_p     = awaddr;
      w_stall  = wvalid && !wready;
      w_p      = {wlast, wdata};
      ar_stall = arvalid && !arready;
      ar_p     = araddr;
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int eb, ee, cyc;
    logic [1:0]  rm;
    logic [15:0] rn, rb, rs;
    logic [7:0]  rl;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
    chk("rst_counts", {cycle_cnt, beat_cnt[15:0], err_cnt}, 0);
    #2 aresetn = 1'b1;
    repeat (2) @(posedge aclk);

    run(2'd0, 16'd2, 16'h0100, 16'h0010, 8'd3, 0, 0);
    chk("wp_beats", beat_cnt, 8);
    chk("wp_errs", err_cnt, 0);

    run(2'd0, 16'd1, 16'h0040, 16'h0000, 8'd0, 0, 0);
    chk("timing_cycles", cycle_cnt, 3);
    chk("timing_done", done, 1);

    run(2'd2, 16'd4, 16'h1000, 16'h0008, 8'd7, 0, 0);
    chk("loop_beats", beat_cnt, 64);
    run(2'd2, 16'd4, 16'h1000, 16'h0008, 8'd7, 1, 0);
    chk("loop_stall_beats", beat_cnt, 64);
    chk("loop_stall_errs", err_cnt, 0);
    run(2'd3, 16'd3, 16'hFFF0, 16'h0011, 8'd5, 1, 1);

    k_zero = 1; k_bad_rid = 1;
    run(2'd1, 16'd1, 16'h0200, 16'h0000, 8'd1, 0, 0);
    chk("err_a", err_cnt, 2);
    k_zero = 0; k_bad_rid = 0;

    k_bad_bid = 1;
    run(2'd0, 16'd3, 16'h0400, 16'h0020, 8'd1, 0, 0);
    chk("bid_errs", err_cnt, 3);
    k_bad_bid = 0;

    k_early = 1;
    run(2'd1, 16'd2, 16'h0500, 16'h0004, 8'd3, 1, 0);
    chk("early_errs", err_cnt, 2);
    chk("early_beats", beat_cnt, 2);
    k_early = 0;

    run(2'd0, 16'd0, 16'h0600, 16'h0001, 8'd2, 0, 0);
    chk("zero_cycles", cycle_cnt, 0);

    for (int t = 0; t < 12; t++) begin
      rm = 2'($urandom_range(0, 3));
      rn = 16'($urandom_range(1, 4));
      rb = 16'($urandom);
      rs = 16'($urandom);
      rl = 8'($urandom_range(0, 7));
      k_bad_bid = ($urandom_range(0, 3) == 0);
      k_zero    = ($urandom_range(0, 3) == 0);
      k_bad_rid = ($urandom_range(0, 3) == 0);
      k_early   = ($urandom_range(0, 3) == 0);
      run(rm, rn, rb, rs, rl, $urandom_range(0, 1) == 1, 0);
    end
    k_bad_bid = 0; k_zero = 0; k_bad_rid = 0; k_early = 0; bp = 0;

    model(2'd0, 16'd4, 16'h0300, 16'h0040, 8'd15, eb, ee);
    cur_len = 8'd15;
    @(posedge aclk); #1;
    mode = 2'd0; num_bursts = 16'd4; base_addr = 16'h0300;
    stride = 16'h0040; burst_len = 8'd15; start = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
    cyc = 0;
    while (!wvalid && cyc < 100) begin
      @(negedge aclk);
      cyc++;
    end
    chk("rst_reach_wd", wvalid, 1);
    @(posedge aclk); #3;
    aresetn = 1'b0;
    #1;
    chk("arst_wvalid", wvalid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    repeat (2) @(posedge aclk);
    #3 aresetn = 1'b1;
    @(negedge aclk);
    chk("post_rst_flags", {busy, done, awvalid, wvalid, arvalid}, 0);
    chk("post_rst_counts", {cycle_cnt, beat_cnt}, 0);
    chk("post_rst_err", err_cnt, 0);
    flush();

    run(2'd1, 16'd2, 16'h0700, 16'h0010, 8'd2, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
